hr_rd_capture: RTL

HR_RD_CAPTURE -- requirements
Module: hr_rd_capture

---
 rtl/hr_rd_capture.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hr_rd_capture.sv
// rtl/hr_rd_capture.sv - HyperRAM read-data capture: pairs IDDR DQ bytes by RWDS into 16-bit words
// Handles both RWDS phase alignments and aborts a burst after TIMEOUT idle samples.
module hr_rd_capture #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_start,
  input  logic [7:0]  rd_len,
  input  logic [7:0]  dq_ris,
  input  logic [7:0]  dq_fal,
  input  logic        rwds_ris,
  input  logic        rwds_fal,
  output logic [15:0] rd_d,
  output logic        rd_rdy,
  output logic        rd_done,
  output logic        rd_timeout,
  output logic [7:0]  rd_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT_RWDS, DATA, FINISH} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [7:0]  r_timer;
  logic [7:0]  r_held_msb;
  logic        r_held_vld;
  logic        r_align;
  logic [15:0] r_d;
  logic        r_rdy;
  logic        r_done;
  logic        r_timeout;

  logic        w_start;
  logic        w_cap;
  logic        w_mis_entry;
  logic        w_hold_ld;
  logic        w_hold_clr;
  logic        w_tmo;
  logic [15:0] w_word;
  logic [7:0]  w_cnt_nxt;

  assign w_start   = (r_state == IDLE) && rd_start;
  assign w_cnt_nxt = r_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cap       = 1'b0;
    w_mis_entry = 1'b0;
    w_hold_ld   = 1'b0;
    w_hold_clr  = 1'b0;
    w_tmo       = 1'b0;
    w_word      = 16'h0000;
    case (r_state)
      IDLE: begin
        if (rd_start) w_next = (rd_len != 8'd0) ? WAIT_RWDS : FINISH;
      end
      WAIT_RWDS: begin
        if (rwds_ris && !rwds_fal) begin
          w_cap  = 1'b1;
          w_word = {dq_ris, dq_fal};
        end else if (!rwds_ris && rwds_fal) begin
          w_mis_entry = 1'b1;
          w_next      = DATA;
        end
      end
      DATA: begin
        if (!r_align) begin
          if (rwds_ris && !rwds_fal) begin
            w_cap  = 1'b1;
            w_word = {dq_ris, dq_fal};
          end
        end else begin
          // Shifted phase: the held falling byte pairs with this cycle's rising byte.
          if (!rwds_ris && r_held_vld) begin
            w_cap  = 1'b1;
            w_word = {r_held_msb, dq_ris};
          end
          w_hold_ld  = rwds_fal;
          w_hold_clr = !rwds_fal;
        end
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (r_state == WAIT_RWDS || r_state == DATA) begin
      if (w_cap) begin
        w_next = (w_cnt_nxt == r_len) ? FINISH : DATA;
      end else if (r_timer == TMO_LAST) begin
        w_tmo  = 1'b1;
        w_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= 8'd0;
      r_cnt      <= 8'd0;
      r_timer    <= 8'd0;
      r_held_msb <= 8'd0;
      r_held_vld <= 1'b0;
      r_align    <= 1'b0;
      r_d        <= 16'h0000;
      r_rdy      <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_rdy     <= w_cap;
      r_done    <= (r_state == FINISH);
      r_timeout <= w_tmo;
      if (w_cap) begin
        r_d     <= w_word;
        r_cnt   <= w_cnt_nxt;
        r_timer <= 8'd0;
      end else if (r_state != IDLE) begin
        r_timer <= r_timer + 8'd1;
      end
      if (w_start) begin
        r_len      <= rd_len;
        r_cnt      <= 8'd0;
        r_timer    <= 8'd0;
        r_align    <= 1'b0;
        r_held_vld <= 1'b0;
      end
      if (w_mis_entry) begin
        r_align    <= 1'b1;
        r_held_msb <= dq_fal;
        r_held_vld <= 1'b1;
      end else if (w_hold_ld) begin
        r_held_msb <= dq_fal;
        r_held_vld <= 1'b1;
      end else if (w_hold_clr) begin
        r_held_vld <= 1'b0;
      end
    end
  end

  assign rd_d       = r_d;
  assign rd_rdy     = r_rdy;
  assign rd_done    = r_done;
  assign rd_timeout = r_timeout;
  assign rd_cnt     = r_cnt;
  assign busy       = (r_state != IDLE);

endmodule
